knn_distance_feeder: RTL and testbench

- Producer side of the bitonic_sort distance interface.
- Accepts one labelled distance per cycle from the distance-compute stage over a valid/ready handshake, packs LANES words into one beat, and drives i_distance, i_sorting_indication and i_clr_smallest_data_regs of the sorter.
- Per query: clears the sorter's smallest-5 registers, streams all training-point distances, pads the last partial beat, waits for the sorter to drain, then signals done so the classifier can sample o_5_smallest_distances_group_bit.

---
 rtl/knn_distance_feeder_pkg.sv | 23 ++
 rtl/knn_distance_feeder_if.sv | 13 +
 rtl/knn_distance_feeder_lane_packer.sv | 50 +++++
 rtl/knn_distance_feeder.sv | 99 +++++++++
 tb/tb_knn_distance_feeder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/knn_distance_feeder_pkg.sv
// Shared types and constants for the k-NN distance feeder and its lane packer.
package knn_pkg;

  localparam int unsigned REGISTER_SIZE = 11;
  localparam int unsigned LANES         = 4;
  localparam int unsigned LANE_W        = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [REGISTER_SIZE:0]            dist_word_t;
  typedef logic [LANES-1:0][REGISTER_SIZE:0] beat_t;

  // Padding sorts behind every real distance.
  localparam dist_word_t DIST_PAD = '1;
  localparam beat_t      BEAT_PAD = {LANES{DIST_PAD}};

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCollect,
    StDrain,
    StDone
  } feeder_state_e;

endpackage

// File: rtl/knn_distance_feeder_if.sv
// Upstream valid/ready word channel from the distance-compute stage into the feeder.
interface knn_distance_feeder_if;
  import knn_pkg::*;

  logic                     i_valid;
  logic                     o_ready;
  logic [REGISTER_SIZE-1:0] i_distance;
  logic                     i_group;

  modport master (output i_valid, output i_distance, output i_group, input o_ready);
  modport slave  (input i_valid, input i_distance, input i_group, output o_ready);

endinterface

// File: rtl/knn_distance_feeder_lane_packer.sv
// Packs accepted words into LANES-wide beats; pads and flushes the final partial beat.
module knn_lane_packer
  import knn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_accept,
  input  logic       i_last,
  input  dist_word_t i_word,
  output beat_t      o_distance,
  output logic       o_beat
);

  beat_t             r_lanes;
  beat_t             r_distance;
  logic              r_beat;
  logic [LANE_W-1:0] r_lane_idx;

  beat_t w_filled;
  logic  w_flush;

  always_comb begin
    w_filled             = r_lanes;
    w_filled[r_lane_idx] = i_word;
    w_flush = i_accept && ((r_lane_idx == LANE_W'(LANES - 1)) || i_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lanes    <= BEAT_PAD;
      r_distance <= BEAT_PAD;
      r_beat     <= 1'b0;
      r_lane_idx <= '0;
    end else begin
      r_beat     <= w_flush;
      r_distance <= w_flush ? w_filled : BEAT_PAD;
      if (w_flush) begin
        r_lanes    <= BEAT_PAD;
        r_lane_idx <= '0;
      end else if (i_accept) begin
        r_lanes    <= w_filled;
        r_lane_idx <= r_lane_idx + 1'b1;
      end
    end
  end

  assign o_distance = r_distance;
  assign o_beat     = r_beat;

endmodule

// File: rtl/knn_distance_feeder.sv
// Query sequencer feeding labelled distances into the bitonic sorter: clear, stream, drain, done.
module knn_distance_feeder
  import knn_pkg::*;
#(
  parameter int unsigned CNT_W        = 11,
  parameter int unsigned SORT_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_num_points,
  knn_distance_feeder_if.slave io_up,
  output beat_t                o_distance,
  output logic                 o_sorting_indication,
  output logic                 o_clr_smallest_data_regs,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned      DRAIN_W = (SORT_LATENCY > 1) ? $clog2(SORT_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MAX_PTS = CNT_W'(1) << (CNT_W - 1);

  feeder_state_e      r_state, w_state_d;
  logic [CNT_W-1:0]   r_remaining, w_remaining_d;
  logic [DRAIN_W-1:0] r_drain_cnt, w_drain_d;
  logic               r_ready, r_clr, r_busy, r_done;
  logic               w_accept;

  assign w_accept = io_up.i_valid & r_ready;

  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    w_drain_d     = r_drain_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_remaining_d = (i_num_points > MAX_PTS) ? MAX_PTS : i_num_points;
          w_state_d     = StClear;
        end
      end
      StClear: w_state_d = (r_remaining == '0) ? StDone : StCollect;
      StCollect: begin
        // remaining reaches zero in the cycle the final beat is on the bus
        if (r_remaining == '0) begin
          w_state_d = StDrain;
        end else if (w_accept) begin
          w_remaining_d = r_remaining - CNT_W'(1);
        end
      end
      StDrain: begin
        if (r_drain_cnt == DRAIN_W'(SORT_LATENCY - 1)) begin
          w_drain_d = '0;
          w_state_d = StDone;
        end else begin
          w_drain_d = r_drain_cnt + 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_drain_cnt <= '0;
      r_ready     <= 1'b0;
      r_clr       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_remaining <= w_remaining_d;
      r_drain_cnt <= w_drain_d;
      r_ready     <= (w_state_d == StCollect) && (w_remaining_d != '0);
      r_clr       <= (w_state_d == StClear);
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone);
    end
  end

  knn_lane_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_last     (r_remaining == CNT_W'(1)),
    .i_word     ({io_up.i_distance, io_up.i_group}),
    .o_distance (o_distance),
    .o_beat     (o_sorting_indication)
  );

  assign io_up.o_ready            = r_ready;
  assign o_clr_smallest_data_regs = r_clr;
  assign o_busy                   = r_busy;
  assign o_done                   = r_done;

endmodule

// File: tb/tb_knn_distance_feeder.sv
// Self-checking bench: directed query table plus random queries against a chunk/pad reference.
module tb_knn_distance_feeder;
  import knn_pkg::*;

  localparam int CNT_W  = 11;
  localparam int SL     = 3;
  localparam int MAXPTS = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_num_points = '0;
  beat_t            o_distance;
  logic             o_sorting_indication, o_clr_smallest_data_regs, o_busy, o_done;

  knn_distance_feeder_if io_up ();

  knn_distance_feeder #(.CNT_W(CNT_W), .SORT_LATENCY(SL)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_start                  (i_start),
    .i_num_points             (i_num_points),
    .io_up                    (io_up),
    .o_distance               (o_distance),
    .o_sorting_indication     (o_sorting_indication),
    .o_clr_smallest_data_regs (o_clr_smallest_data_regs),
    .o_busy                   (o_busy),
    .o_done                   (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation record for the current query window.
  beat_t      beats[$];
  int         beat_cyc[$], acc_cyc[$], clr_cyc[$], done_cyc[$];
  int         start_cyc, ready_cnt, pad_bad;
  dist_word_t sent_q[$];

  always @(negedge clk) begin
    if (i_start && start_cyc < 0) start_cyc = cyc;
    if (o_clr_smallest_data_regs) clr_cyc.push_back(cyc);
    if (o_sorting_indication) begin
      beats.push_back(o_distance);
      beat_cyc.push_back(cyc);
    end else if (o_distance !== BEAT_PAD) begin
      pad_bad++;
    end
    if (o_done) done_cyc.push_back(cyc);
    if (io_up.o_ready) ready_cnt++;
    if (io_up.i_valid && io_up.o_ready) acc_cyc.push_back(cyc);
  end

  task automatic mon_clear();
    beats.delete(); beat_cyc.delete(); acc_cyc.delete(); clr_cyc.delete();
    done_cyc.delete(); sent_q.delete();
    start_cyc = -1; ready_cnt = 0; pad_bad = 0;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dist"}, o_distance, BEAT_PAD);
    check({tag, "_ctl"}, {o_sorting_indication, o_clr_smallest_data_regs, io_up.o_ready,
                          o_busy, o_done}, 0);
  endtask

  task automatic start_query(input int n);
    @(posedge clk); #1;
    i_start = 1'b1; i_num_points = n[CNT_W-1:0];
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: every other cycle, 2: random gaps
  task automatic drive_words(input int n, input int mode, input bit directed, input bit mid);
    int k = 0;
    bit started = 0;
    for (int i = 0; i < n; i++) begin
      dist_word_t w;
      bit got = 0;
      w = directed ? {i[REGISTER_SIZE-1:0], i[0]} : dist_word_t'($urandom);
      sent_q.push_back(w);
      io_up.i_distance = w[REGISTER_SIZE:1];
      io_up.i_group    = w[0];
      for (int t = 0; t < 500 && !got; t++) begin
        io_up.i_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) :
                        ($urandom_range(0, 3) != 0);
        k++;
        if (mid && i == 1 && !started) begin
          i_start = 1'b1; i_num_points = 11'd7; started = 1;
        end
        @(negedge clk);
        got = io_up.i_valid && io_up.o_ready;
        @(posedge clk); #1;
        i_start = 1'b0;
      end
      if (!got) begin
        n_checks++; n_errors++;
        $display("FAIL accept_timeout got word %0d expected accepted", i);
        io_up.i_valid = 1'b0;
        return;
      end
    end
    io_up.i_valid = 1'b0;
  endtask

  task automatic run_query(input int n, input int mode, input bit directed, input bit mid,
                           input int exp_beats);
    int nc, expb, exp_done;
    nc   = (n > MAXPTS) ? MAXPTS : n;
    expb = (nc + LANES - 1) / LANES;
    mon_clear();
    start_query(n);
    drive_words(nc, mode, directed, mid);
    for (int k = 0; k < 100 && done_cyc.size() == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("clr_count", clr_cyc.size(), 1);
    check("clr_time", (clr_cyc.size() > 0) ? clr_cyc[0] : -1, start_cyc + 1);
    check("beat_count", beats.size(), (exp_beats >= 0) ? exp_beats : expb);
    check("accepts", acc_cyc.size(), nc);
    for (int j = 0; j < beats.size() && j < expb; j++) begin
      beat_t exp_b;
      int    last_acc;
      for (int l = 0; l < LANES; l++) begin
        int idx = j * LANES + l;
        exp_b[l] = (idx < nc) ? sent_q[idx] : DIST_PAD;
      end
      check("beat_data", beats[j], exp_b);
      last_acc = j * LANES + LANES - 1;
      if (last_acc > nc - 1) last_acc = nc - 1;
      if (last_acc < acc_cyc.size()) check("beat_time", beat_cyc[j], acc_cyc[last_acc] + 1);
    end
    check("done_count", done_cyc.size(), 1);
    if (nc == 0) begin
      exp_done = start_cyc + 2;
      check("ready_n0", ready_cnt, 0);
    end else begin
      exp_done = (beat_cyc.size() > 0) ? beat_cyc[beat_cyc.size() - 1] + SL + 1 : -100;
    end
    check("done_time", (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
    check("pad_idle", pad_bad, 0);
    check("busy_end", o_busy, 0);
  endtask

  typedef struct {
    int n;
    int mode;
    bit directed;
    bit mid;
    int exp_beats;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 8,    mode: 0, directed: 1, mid: 0, exp_beats: 2};
    vecs[1] = '{n: 5,    mode: 0, directed: 1, mid: 0, exp_beats: 2};
    vecs[2] = '{n: 0,    mode: 0, directed: 1, mid: 0, exp_beats: 0};
    vecs[3] = '{n: 6,    mode: 1, directed: 1, mid: 0, exp_beats: 2};
    vecs[4] = '{n: 3,    mode: 0, directed: 1, mid: 1, exp_beats: 1};
    vecs[5] = '{n: 1,    mode: 0, directed: 1, mid: 0, exp_beats: 1};
    vecs[6] = '{n: 1024, mode: 0, directed: 1, mid: 0, exp_beats: 256};
    vecs[7] = '{n: 1500, mode: 2, directed: 0, mid: 0, exp_beats: 256};
    vecs[8] = '{n: 13,   mode: 2, directed: 0, mid: 0, exp_beats: 4};

    io_up.i_valid = 1'b0; io_up.i_distance = '0; io_up.i_group = 1'b0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 9; v++)
      run_query(vecs[v].n, vecs[v].mode, vecs[v].directed, vecs[v].mid, vecs[v].exp_beats);

    // Reset mid-query after two accepts: nothing may leak out, then a fresh query.
    mon_clear();
    start_query(8);
    drive_words(2, 0, 1, 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_no_beat", beats.size(), 0);
    check("reset_no_done", done_cyc.size(), 0);
    run_query(4, 0, 0, 0, 1);

    for (int r = 0; r < 10; r++)
      run_query($urandom_range(0, 40), $urandom_range(0, 2), 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
